sdram_rw_sched: RTL and testbench

// - Schedules SDRAM burst traffic between the user write FIFO and the user read FIFO, sitting

---
 rtl/sdram_pkg.sv | 21 ++
 rtl/sdram_addr_gen.sv | 78 +++++++
 rtl/sdram_rw_sched.sv | 191 +++++++++++++++++++
 tb/tb_sdram_rw_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM read/write burst scheduler.
package sdram_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int LEN_W_DEF  = 10;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        ARB       = 3'd1,
        WR_REQ    = 3'd2,
        WR_DATA   = 3'd3,
        RD_REQ    = 3'd4,
        RD_DATA   = 3'd5
    } sched_state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

endpackage

// File: rtl/sdram_addr_gen.sv
// Per-port burst address pointer with wrap-around, load edge detect and FIFO clear pulse.
module sdram_addr_gen
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              allow,
    input  logic              advance,
    input  logic              load,
    input  logic [ADDR_W-1:0] min,
    input  logic [ADDR_W-1:0] max,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] ptr,
    output logic              clr,
    output logic              busy
);

    logic [ADDR_W-1:0] ptr_r;
    logic              clr_r;
    logic              load_d_r;
    logic              pending_r;
    logic              load_rise_s;
    logic              service_s;

    // One extra bit on the sum so a pointer near the top of the address space cannot alias low.
    function automatic logic [ADDR_W-1:0] next_ptr(
        input logic [ADDR_W-1:0] cur,
        input logic [LEN_W-1:0]  step,
        input logic [ADDR_W-1:0] lo,
        input logic [ADDR_W-1:0] hi
    );
        logic [ADDR_W:0] sum_s;
        sum_s = {1'b0, cur} + (ADDR_W+1)'(step);
        if (sum_s > {1'b0, hi}) begin
            next_ptr = lo;
        end else begin
            next_ptr = sum_s[ADDR_W-1:0];
        end
    endfunction

    assign load_rise_s = load & ~load_d_r;
    assign service_s   = allow & pending_r;

    // Pointer, pending load flag and clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r     <= {ADDR_W{1'b0}};
            clr_r     <= 1'b0;
            load_d_r  <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            load_d_r <= load;
            clr_r    <= service_s;
            if (service_s) begin
                ptr_r <= min;
            end else if (start) begin
                ptr_r <= min;
            end else if (advance) begin
                ptr_r <= next_ptr(ptr_r, len, min, max);
            end
            // A new edge arriving in the service cycle must not be lost.
            if (load_rise_s) begin
                pending_r <= 1'b1;
            end else if (service_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign ptr  = ptr_r;
    assign clr  = clr_r;
    assign busy = pending_r | clr_r;

endmodule

// File: rtl/sdram_rw_sched.sv
// Round-robin write/read burst scheduler between the user FIFOs and the SDRAM controller.
module sdram_rw_sched
    import sdram_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int USED_W   = 10,
    parameter int RD_DEPTH = 1024
) (
    input  logic              ref_clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic              sdram_read_valid,
    input  logic [ADDR_W-1:0] wr_minaddr,
    input  logic [ADDR_W-1:0] wr_maxaddr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic              wr_load,
    input  logic [USED_W-1:0] wr_fifo_used,
    input  logic [ADDR_W-1:0] rd_minaddr,
    input  logic [ADDR_W-1:0] rd_maxaddr,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic              rd_load,
    input  logic [USED_W-1:0] rd_fifo_used,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic [LEN_W-1:0]  sdram_wr_burst,
    output logic [LEN_W-1:0]  sdram_rd_burst,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic              wr_fifo_clr,
    output logic              rd_fifo_clr
);

    sched_state_t      state_r, state_next_s;
    grant_t            last_grant_r;
    logic              wr_req_r, rd_req_r;
    logic [ADDR_W-1:0] wr_addr_r, rd_addr_r;
    logic [LEN_W-1:0]  wr_burst_r, rd_burst_r;
    logic [ADDR_W-1:0] wr_ptr_s, rd_ptr_s;
    logic              wr_busy_s, rd_busy_s;
    logic              wr_elig_s, rd_elig_s;
    logic              wr_adv_s, rd_adv_s;
    logic              start_s, allow_s;

    assign start_s = (state_r == WAIT_INIT) && sdram_init_done;
    assign allow_s = (state_r == WAIT_INIT) || (state_r == ARB);

    assign wr_elig_s = !wr_busy_s && (32'(wr_fifo_used) >= 32'(wr_len));
    assign rd_elig_s = !rd_busy_s && sdram_read_valid &&
                       ((32'(rd_fifo_used) + 32'(rd_len)) <= 32'(RD_DEPTH));

    sdram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_gen (
        .clk     (ref_clk),
        .rst_n   (rst_n),
        .start   (start_s),
        .allow   (allow_s),
        .advance (wr_adv_s),
        .load    (wr_load),
        .min     (wr_minaddr),
        .max     (wr_maxaddr),
        .len     (wr_len),
        .ptr     (wr_ptr_s),
        .clr     (wr_fifo_clr),
        .busy    (wr_busy_s)
    );

    sdram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_gen (
        .clk     (ref_clk),
        .rst_n   (rst_n),
        .start   (start_s),
        .allow   (allow_s),
        .advance (rd_adv_s),
        .load    (rd_load),
        .min     (rd_minaddr),
        .max     (rd_maxaddr),
        .len     (rd_len),
        .ptr     (rd_ptr_s),
        .clr     (rd_fifo_clr),
        .busy    (rd_busy_s)
    );

    // Next-state, arbitration and pointer-advance strobes.
    always_comb begin
        state_next_s = state_r;
        wr_adv_s     = 1'b0;
        rd_adv_s     = 1'b0;
        case (state_r)
            WAIT_INIT: begin
                if (sdram_init_done) begin
                    state_next_s = ARB;
                end else begin
                    state_next_s = WAIT_INIT;
                end
            end
            ARB: begin
                if (!sdram_init_done) begin
                    state_next_s = WAIT_INIT;
                end else if (wr_elig_s && rd_elig_s) begin
                    state_next_s = (last_grant_r == GNT_WR) ? RD_REQ : WR_REQ;
                end else if (wr_elig_s) begin
                    state_next_s = WR_REQ;
                end else if (rd_elig_s) begin
                    state_next_s = RD_REQ;
                end else begin
                    state_next_s = ARB;
                end
            end
            WR_REQ: begin
                if (sdram_wr_ack) begin
                    state_next_s = WR_DATA;
                end else begin
                    state_next_s = WR_REQ;
                end
            end
            WR_DATA: begin
                if (!sdram_wr_ack) begin
                    wr_adv_s     = 1'b1;
                    state_next_s = sdram_init_done ? ARB : WAIT_INIT;
                end else begin
                    state_next_s = WR_DATA;
                end
            end
            RD_REQ: begin
                if (sdram_rd_ack) begin
                    state_next_s = RD_DATA;
                end else begin
                    state_next_s = RD_REQ;
                end
            end
            RD_DATA: begin
                if (!sdram_rd_ack) begin
                    rd_adv_s     = 1'b1;
                    state_next_s = sdram_init_done ? ARB : WAIT_INIT;
                end else begin
                    state_next_s = RD_DATA;
                end
            end
            default: begin
                state_next_s = WAIT_INIT;
            end
        endcase
    end

    // State register and round-robin history.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= WAIT_INIT;
            last_grant_r <= GNT_RD;
        end else begin
            state_r <= state_next_s;
            if (wr_adv_s) begin
                last_grant_r <= GNT_WR;
            end else if (rd_adv_s) begin
                last_grant_r <= GNT_RD;
            end
        end
    end

    // Request strobes plus address/length captured at grant and held through the burst.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_req_r   <= 1'b0;
            rd_req_r   <= 1'b0;
            wr_addr_r  <= {ADDR_W{1'b0}};
            rd_addr_r  <= {ADDR_W{1'b0}};
            wr_burst_r <= {LEN_W{1'b0}};
            rd_burst_r <= {LEN_W{1'b0}};
        end else begin
            wr_req_r <= (state_next_s == WR_REQ);
            rd_req_r <= (state_next_s == RD_REQ);
            if ((state_r == ARB) && (state_next_s == WR_REQ)) begin
                wr_addr_r  <= wr_ptr_s;
                wr_burst_r <= wr_len;
            end
            if ((state_r == ARB) && (state_next_s == RD_REQ)) begin
                rd_addr_r  <= rd_ptr_s;
                rd_burst_r <= rd_len;
            end
        end
    end

    assign sdram_wr_req   = wr_req_r;
    assign sdram_rd_req   = rd_req_r;
    assign sdram_wr_addr  = wr_addr_r;
    assign sdram_rd_addr  = rd_addr_r;
    assign sdram_wr_burst = wr_burst_r;
    assign sdram_rd_burst = rd_burst_r;

endmodule

// File: tb/tb_sdram_rw_sched.sv
// Scoreboard bench for sdram_rw_sched: expected bursts are queued as stimulus is set up.
module tb_sdram_rw_sched;

    logic        ref_clk = 1'b0;
    logic        rst_n;
    logic        sdram_init_done, sdram_read_valid;
    logic [23:0] wr_minaddr, wr_maxaddr, rd_minaddr, rd_maxaddr;
    logic [9:0]  wr_len, rd_len, wr_fifo_used, rd_fifo_used;
    logic        wr_load, rd_load;
    logic        sdram_wr_req, sdram_rd_req;
    logic [23:0] sdram_wr_addr, sdram_rd_addr;
    logic [9:0]  sdram_wr_burst, sdram_rd_burst;
    logic        sdram_wr_ack, sdram_rd_ack;
    logic        wr_fifo_clr, rd_fifo_clr;

    typedef struct packed {
        logic        is_wr;
        logic [23:0] addr;
        logic [9:0]  len;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 ref_clk = ~ref_clk;

    sdram_rw_sched #(.ADDR_W(24), .LEN_W(10), .USED_W(10), .RD_DEPTH(1024)) dut (
        .ref_clk          (ref_clk),
        .rst_n            (rst_n),
        .sdram_init_done  (sdram_init_done),
        .sdram_read_valid (sdram_read_valid),
        .wr_minaddr       (wr_minaddr),
        .wr_maxaddr       (wr_maxaddr),
        .wr_len           (wr_len),
        .wr_load          (wr_load),
        .wr_fifo_used     (wr_fifo_used),
        .rd_minaddr       (rd_minaddr),
        .rd_maxaddr       (rd_maxaddr),
        .rd_len           (rd_len),
        .rd_load          (rd_load),
        .rd_fifo_used     (rd_fifo_used),
        .sdram_wr_req     (sdram_wr_req),
        .sdram_rd_req     (sdram_rd_req),
        .sdram_wr_addr    (sdram_wr_addr),
        .sdram_rd_addr    (sdram_rd_addr),
        .sdram_wr_burst   (sdram_wr_burst),
        .sdram_rd_burst   (sdram_rd_burst),
        .sdram_wr_ack     (sdram_wr_ack),
        .sdram_rd_ack     (sdram_rd_ack),
        .wr_fifo_clr      (wr_fifo_clr),
        .rd_fifo_clr      (rd_fifo_clr)
    );

    // Wait (bounded) for the next request; reports what was seen, no judgement here.
    task automatic wait_req(output bit got, output exp_t seen);
        got  = 1'b0;
        seen = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ref_clk);
            if (sdram_wr_req || sdram_rd_req) begin
                got        = 1'b1;
                seen.is_wr = sdram_wr_req;
                seen.addr  = sdram_wr_req ? sdram_wr_addr : sdram_rd_addr;
                seen.len   = sdram_wr_req ? sdram_wr_burst : sdram_rd_burst;
                return;
            end
        end
    endtask

    // SDRAM controller stand-in: hold ack for n cycles, flag any request seen meanwhile.
    task automatic ack_burst(input bit is_wr, input int n, output bit ovl);
        ovl = 1'b0;
        if (is_wr) sdram_wr_ack = 1'b1;
        else       sdram_rd_ack = 1'b1;
        repeat (n) begin
            @(negedge ref_clk);
            if (sdram_wr_req || sdram_rd_req) ovl = 1'b1;
        end
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge ref_clk);
        tests_run++;
        if ({sdram_wr_req, sdram_rd_req, wr_fifo_clr, rd_fifo_clr} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b, expected 0000",
                     {sdram_wr_req, sdram_rd_req, wr_fifo_clr, rd_fifo_clr});
        end
        tests_run++;
        if ({sdram_wr_addr, sdram_rd_addr, sdram_wr_burst, sdram_rd_burst} !== 68'd0) begin
            tests_failed++;
            $display("FAIL reset_addr_burst: got %h/%h/%0d/%0d, expected all 0",
                     sdram_wr_addr, sdram_rd_addr, sdram_wr_burst, sdram_rd_burst);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_init_gating();
        int   reqs = 0;
        bit   got = 1'b0, ovl;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            @(negedge ref_clk);
            if (sdram_wr_req || sdram_rd_req) reqs++;
        end
        tests_run++;
        if (reqs !== 0) begin
            tests_failed++;
            $display("FAIL init_gating_idle: got %0d req cycles, expected 0", reqs);
        end
        exp_q.push_back('{1'b1, 24'h000040, 10'd256});
        sdram_init_done = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge ref_clk);
            if (sdram_wr_req && !got) got = 1'b1;
        end
        e = exp_q.pop_front();
        tests_run++;
        if (got !== 1'b1 || sdram_wr_addr !== e.addr || sdram_wr_burst !== e.len) begin
            tests_failed++;
            $display("FAIL init_first_req: got req=%0b addr=%h len=%0d, expected req=1 addr=%h len=%0d",
                     got, sdram_wr_addr, sdram_wr_burst, e.addr, e.len);
        end
        wr_fifo_used = 10'd0;
        ack_burst(1'b1, 3, ovl);
    endtask

    task automatic test_write_wrap();
        int   clr_cnt = 0;
        bit   got, ovl;
        exp_t e, s;
        wr_minaddr = 24'h000000;
        wr_maxaddr = 24'h0003FF;
        wr_load    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge ref_clk);
            wr_load = 1'b0;
            if (wr_fifo_clr) clr_cnt++;
        end
        tests_run++;
        if (clr_cnt !== 1) begin
            tests_failed++;
            $display("FAIL load_idle_clr: got %0d clr pulses, expected 1", clr_cnt);
        end
        exp_q.push_back('{1'b1, 24'd0,   10'd256});
        exp_q.push_back('{1'b1, 24'd256, 10'd256});
        exp_q.push_back('{1'b1, 24'd512, 10'd256});
        exp_q.push_back('{1'b1, 24'd768, 10'd256});
        exp_q.push_back('{1'b1, 24'd0,   10'd256});
        wr_fifo_used = 10'd1023;
        for (int i = 0; i < 5; i++) begin
            wait_req(got, s);
            e = exp_q.pop_front();
            tests_run++;
            if (got !== 1'b1 || s !== e) begin
                tests_failed++;
                $display("FAIL wrap_burst%0d: got req=%0b wr=%0b addr=%h len=%0d, expected wr=%0b addr=%h len=%0d",
                         i, got, s.is_wr, s.addr, s.len, e.is_wr, e.addr, e.len);
            end
            if (i == 4) wr_fifo_used = 10'd0;
            ack_burst(1'b1, 3, ovl);
        end
    endtask

    task automatic test_round_robin();
        bit   got, ovl;
        exp_t e, s;
        exp_q.push_back('{1'b0, 24'h001000, 10'd128});
        exp_q.push_back('{1'b1, 24'd256,    10'd256});
        exp_q.push_back('{1'b0, 24'h001080, 10'd128});
        exp_q.push_back('{1'b1, 24'd512,    10'd256});
        wr_fifo_used     = 10'd1023;
        rd_fifo_used     = 10'd0;
        sdram_read_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req(got, s);
            e = exp_q.pop_front();
            tests_run++;
            if (got !== 1'b1 || s !== e || (sdram_wr_req && sdram_rd_req)) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got req=%0b wr=%0b addr=%h len=%0d, expected wr=%0b addr=%h len=%0d",
                         i, got, s.is_wr, s.addr, s.len, e.is_wr, e.addr, e.len);
            end
            if (i == 3) begin
                wr_fifo_used     = 10'd0;
                sdram_read_valid = 1'b0;
            end
            ack_burst(s.is_wr, 4, ovl);
            tests_run++;
            if (ovl !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_overlap%0d: got req during ack=%0b, expected 0", i, ovl);
            end
        end
    endtask

    task automatic test_rd_backpressure();
        int   reqs = 0;
        bit   got, ovl;
        exp_t e, s;
        sdram_read_valid = 1'b1;
        rd_fifo_used     = 10'd900;
        rd_len           = 10'd256;
        for (int i = 0; i < 20; i++) begin
            @(negedge ref_clk);
            if (sdram_rd_req || sdram_wr_req) reqs++;
        end
        tests_run++;
        if (reqs !== 0) begin
            tests_failed++;
            $display("FAIL rd_backpressure_hold: got %0d req cycles, expected 0", reqs);
        end
        exp_q.push_back('{1'b0, 24'h001100, 10'd256});
        rd_fifo_used = 10'd768;
        wait_req(got, s);
        e = exp_q.pop_front();
        tests_run++;
        if (got !== 1'b1 || s !== e) begin
            tests_failed++;
            $display("FAIL rd_backpressure_release: got req=%0b wr=%0b addr=%h len=%0d, expected wr=%0b addr=%h len=%0d",
                     got, s.is_wr, s.addr, s.len, e.is_wr, e.addr, e.len);
        end
        sdram_read_valid = 1'b0;
        ack_burst(1'b0, 3, ovl);
    endtask

    task automatic test_load_mid_burst();
        int   clr_busy = 0;
        int   clr_after = 0;
        bit   got, ovl;
        exp_t e, s;
        wr_len = 10'd128;
        exp_q.push_back('{1'b1, 24'd768, 10'd128});
        wr_fifo_used = 10'd1023;
        wait_req(got, s);
        e = exp_q.pop_front();
        tests_run++;
        if (got !== 1'b1 || s !== e) begin
            tests_failed++;
            $display("FAIL load_mid_first: got req=%0b wr=%0b addr=%h len=%0d, expected wr=%0b addr=%h len=%0d",
                     got, s.is_wr, s.addr, s.len, e.is_wr, e.addr, e.len);
        end
        sdram_wr_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ref_clk);
            if (i == 0) wr_load = 1'b1;
            if (i == 1) wr_load = 1'b0;
            if (wr_fifo_clr) clr_busy++;
        end
        sdram_wr_ack = 1'b0;
        tests_run++;
        if (clr_busy !== 0) begin
            tests_failed++;
            $display("FAIL load_mid_deferred: got %0d clr pulses during ack, expected 0", clr_busy);
        end
        exp_q.push_back('{1'b1, 24'd0, 10'd128});
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ref_clk);
            if (wr_fifo_clr) clr_after++;
            if (sdram_wr_req || sdram_rd_req) begin
                got = 1'b1;
                break;
            end
        end
        e = exp_q.pop_front();
        tests_run++;
        if (clr_after !== 1) begin
            tests_failed++;
            $display("FAIL load_mid_clr: got %0d clr pulses after ack, expected 1", clr_after);
        end
        tests_run++;
        if (got !== 1'b1 || sdram_wr_req !== 1'b1 || sdram_wr_addr !== e.addr || sdram_wr_burst !== e.len) begin
            tests_failed++;
            $display("FAIL load_mid_next_addr: got req=%0b addr=%h len=%0d, expected req=1 addr=%h len=%0d",
                     got, sdram_wr_addr, sdram_wr_burst, e.addr, e.len);
        end
        wr_fifo_used = 10'd0;
        ack_burst(1'b1, 3, ovl);
    endtask

    task automatic test_reset_mid_burst();
        int   reqs = 0;
        bit   got, ovl;
        exp_t e, s;
        rd_len           = 10'd64;
        rd_fifo_used     = 10'd0;
        sdram_read_valid = 1'b1;
        exp_q.push_back('{1'b0, 24'h001200, 10'd64});
        wait_req(got, s);
        e = exp_q.pop_front();
        tests_run++;
        if (got !== 1'b1 || s !== e) begin
            tests_failed++;
            $display("FAIL rst_mid_req: got req=%0b wr=%0b addr=%h len=%0d, expected wr=%0b addr=%h len=%0d",
                     got, s.is_wr, s.addr, s.len, e.is_wr, e.addr, e.len);
        end
        sdram_rd_ack = 1'b1;
        repeat (2) @(negedge ref_clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({sdram_wr_req, sdram_rd_req, wr_fifo_clr, rd_fifo_clr, sdram_wr_addr, sdram_rd_addr,
             sdram_wr_burst, sdram_rd_burst} !== 72'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got rd_req=%0b rd_addr=%h rd_len=%0d wr_addr=%h, expected all 0",
                     sdram_rd_req, sdram_rd_addr, sdram_rd_burst, sdram_wr_addr);
        end
        sdram_rd_ack    = 1'b0;
        sdram_init_done = 1'b0;
        @(negedge ref_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge ref_clk);
            if (sdram_wr_req || sdram_rd_req) reqs++;
        end
        tests_run++;
        if (reqs !== 0) begin
            tests_failed++;
            $display("FAIL rst_mid_wait_init: got %0d req cycles, expected 0", reqs);
        end
        exp_q.push_back('{1'b0, 24'h001000, 10'd64});
        sdram_init_done = 1'b1;
        wait_req(got, s);
        e = exp_q.pop_front();
        tests_run++;
        if (got !== 1'b1 || s !== e) begin
            tests_failed++;
            $display("FAIL rst_mid_restart: got req=%0b wr=%0b addr=%h len=%0d, expected wr=%0b addr=%h len=%0d",
                     got, s.is_wr, s.addr, s.len, e.is_wr, e.addr, e.len);
        end
        sdram_read_valid = 1'b0;
        ack_burst(1'b0, 3, ovl);
    endtask

    initial begin
        rst_n            = 1'b0;
        sdram_init_done  = 1'b0;
        sdram_read_valid = 1'b0;
        wr_minaddr       = 24'h000040;
        wr_maxaddr       = 24'h0003FF;
        wr_len           = 10'd256;
        wr_load          = 1'b0;
        wr_fifo_used     = 10'd512;
        rd_minaddr       = 24'h001000;
        rd_maxaddr       = 24'h001FFF;
        rd_len           = 10'd128;
        rd_load          = 1'b0;
        rd_fifo_used     = 10'd0;
        sdram_wr_ack     = 1'b0;
        sdram_rd_ack     = 1'b0;

        test_reset();
        test_init_gating();
        test_write_wrap();
        test_round_robin();
        test_rd_backpressure();
        test_load_mid_burst();
        test_reset_mid_burst();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
